led_ramp_scheduler: RTL and testbench



---
 rtl/led_ramp_scheduler.sv | 120 ++++++++++++
 tb/tb_led_ramp_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_ramp_scheduler.sv
// rtl/led_ramp_scheduler.sv - round-robin target arbiter and step-pulse ramp generator for the LED bar controller
// Optional LED_RAMP_ABORT_EN adds an abort input that cancels a ramp in progress.
module led_ramp_scheduler #(
    parameter int LEVELS   = 8,
    parameter int STEP_DIV = 4,
    localparam int LW      = $clog2(LEVELS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [LW-1:0] a_level,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [LW-1:0] b_level,
    output logic          b_ready,
    output logic          up_pulse,
    output logic          down_pulse,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic          owner_b
`ifdef LED_RAMP_ABORT_EN
    ,
    input  logic          abort
`endif
);

    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [LW-1:0] MAX_LVL  = LW'(LEVELS - 1);
    localparam logic [DW-1:0] DIV_LOAD = DW'(STEP_DIV - 1);

    typedef enum logic {S_IDLE, S_RAMP} state_t;

    state_t        r_state, w_state_nxt;
    logic [LW-1:0] r_level, w_level_nxt;
    logic [LW-1:0] r_target, w_target_nxt;
    logic [DW-1:0] r_div, w_div_nxt;
    logic          r_last_b, w_last_b_nxt;
    logic          r_owner_b, w_owner_b_nxt;
    logic          w_grant_a, w_grant_b, w_abort;
    logic [LW-1:0] w_req_level;

`ifdef LED_RAMP_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [LW-1:0] clamp_level(input logic [LW-1:0] lvl);
        if (int'(lvl) > LEVELS - 1) return MAX_LVL;
        return lvl;
    endfunction

    // Ties go to whichever requester was not granted last.
    assign w_grant_a   = a_valid && (!b_valid || r_last_b);
    assign w_grant_b   = b_valid && !w_grant_a;
    assign w_req_level = clamp_level(w_grant_b ? b_level : a_level);

    always_comb begin
        w_state_nxt   = r_state;
        w_level_nxt   = r_level;
        w_target_nxt  = r_target;
        w_div_nxt     = r_div;
        w_last_b_nxt  = r_last_b;
        w_owner_b_nxt = r_owner_b;
        a_ready       = 1'b0;
        b_ready       = 1'b0;
        up_pulse      = 1'b0;
        down_pulse    = 1'b0;
        case (r_state)
            S_IDLE: begin
                a_ready = w_grant_a;
                b_ready = w_grant_b;
                if (w_grant_a || w_grant_b) begin
                    w_target_nxt  = w_req_level;
                    w_last_b_nxt  = w_grant_b;
                    w_owner_b_nxt = w_grant_b;
                    w_div_nxt     = DIV_LOAD;
                    if (w_req_level != r_level) w_state_nxt = S_RAMP;
                end
            end
            S_RAMP: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_div == '0) begin
                    up_pulse    = (r_target > r_level);
                    down_pulse  = !up_pulse;
                    w_level_nxt = up_pulse ? r_level + 1'b1 : r_level - 1'b1;
                    w_div_nxt   = DIV_LOAD;
                    if (w_level_nxt == r_target) w_state_nxt = S_IDLE;
                end else begin
                    w_div_nxt = r_div - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_level   <= '0;
            r_target  <= '0;
            r_div     <= '0;
            r_last_b  <= 1'b1;
            r_owner_b <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_level   <= w_level_nxt;
            r_target  <= w_target_nxt;
            r_div     <= w_div_nxt;
            r_last_b  <= w_last_b_nxt;
            r_owner_b <= w_owner_b_nxt;
        end
    end

    assign level   = r_level;
    assign busy    = (r_state == S_RAMP);
    assign owner_b = r_owner_b;

endmodule

// File: tb/tb_led_ramp_scheduler.sv
// tb/tb_led_ramp_scheduler.sv - self-checking bench for led_ramp_scheduler
module tb_led_ramp_scheduler;
    localparam int SD = 4;
    localparam int L0 = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [2:0] a_level = '0, b_level = '0;
    logic       a_ready, b_ready, up_pulse, down_pulse, busy, owner_b;
    logic [2:0] level;

    logic       c_valid = 1'b0, c_bvalid = 1'b0;
    logic [2:0] c_level = '0, c_blevel = '0;
    logic       c_ready, c_bready, c_up, c_down, c_busy, c_owner;
    logic [2:0] c_level_o;

    logic       ab_now;
`ifdef LED_RAMP_ABORT_EN
    logic abort = 1'b0;
    assign ab_now = abort;
`else
    assign ab_now = 1'b0;
`endif

    led_ramp_scheduler #(.LEVELS(L0), .STEP_DIV(SD)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_level(a_level), .a_ready(a_ready),
        .b_valid(b_valid), .b_level(b_level), .b_ready(b_ready),
        .up_pulse(up_pulse), .down_pulse(down_pulse), .level(level),
        .busy(busy), .owner_b(owner_b)
`ifdef LED_RAMP_ABORT_EN
        , .abort(abort)
`endif
    );

    led_ramp_scheduler #(.LEVELS(6), .STEP_DIV(SD)) dut6 (
        .clk(clk), .reset(reset),
        .a_valid(c_valid), .a_level(c_level), .a_ready(c_ready),
        .b_valid(c_bvalid), .b_level(c_blevel), .b_ready(c_bready),
        .up_pulse(c_up), .down_pulse(c_down), .level(c_level_o),
        .busy(c_busy), .owner_b(c_owner)
`ifdef LED_RAMP_ABORT_EN
        , .abort(1'b0)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a ramp is described by its transfer cycle, start level,
    // direction and step count; per-cycle outputs follow in closed form.
    bit m_ramp, m_last_b, m_owner, m_up, ga, gb;
    int m_level, m_start, m_target, m_t, m_n, e_lvl, e_up, e_dn, k, p, lv;

    always @(negedge clk) begin
        if (reset) begin
            m_ramp = 0; m_last_b = 1; m_owner = 0; m_level = 0;
            chk("m_rst_up", up_pulse, 0);
            chk("m_rst_dn", down_pulse, 0);
            chk("m_rst_busy", busy, 0);
            chk("m_rst_level", level, 0);
        end else begin
            e_up = 0; e_dn = 0; e_lvl = m_level; ga = 0; gb = 0; k = 0;
            if (m_ramp) begin
                k = cyc - m_t;
                p = (k - 1) / SD;
                e_lvl = m_up ? m_start + p : m_start - p;
                if (k % SD == 0 && !ab_now) begin
                    if (m_up) e_up = 1; else e_dn = 1;
                end
            end else begin
                ga = a_valid && (!b_valid || m_last_b);
                gb = b_valid && !ga;
            end
            chk("m_a_ready", a_ready, ga);
            chk("m_b_ready", b_ready, gb);
            chk("m_up_pulse", up_pulse, e_up);
            chk("m_down_pulse", down_pulse, e_dn);
            chk("m_level", level, e_lvl);
            chk("m_busy", busy, m_ramp);
            chk("m_owner_b", owner_b, m_owner);
            if (m_ramp) begin
                if (ab_now) begin
                    m_level = e_lvl; m_ramp = 0;
                end else if (k == m_n * SD) begin
                    m_level = m_target; m_ramp = 0;
                end
            end else if (ga || gb) begin
                lv = gb ? int'(b_level) : int'(a_level);
                m_target = (lv > L0 - 1) ? L0 - 1 : lv;
                m_last_b = gb; m_owner = gb;
                if (m_target != m_level) begin
                    m_ramp = 1; m_t = cyc; m_start = m_level;
                    m_up = m_target > m_level;
                    m_n = m_up ? m_target - m_level : m_level - m_target;
                end
            end
        end
    end

    function automatic bit sig(input int w);
        case (w)
            0: return a_ready;
            1: return b_ready;
            default: return c_ready;
        endcase
    endfunction

    task automatic wait_ready(input int w, output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sig(w)) begin ok = 1; break; end
        end
    endtask

    task automatic wait_level(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (level == 3'(target)) begin ok = 1; break; end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; a_valid = 0; b_valid = 0; c_valid = 0;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic request(input bit is_b, input int lvl, input int n, input bit up, input int fin);
        int pulses;
        bit ok;
        @(posedge clk); #1;
        if (is_b) begin b_valid = 1; b_level = 3'(lvl); end
        else begin a_valid = 1; a_level = 3'(lvl); end
        wait_ready(is_b ? 1 : 0, ok);
        chk("req_granted", ok, 1);
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        pulses = 0;
        for (int kk = 1; kk <= n * SD + 1; kk++) begin
            @(negedge clk);
            if (up_pulse || down_pulse) begin
                pulses++;
                chk("req_pulse_spacing", kk % SD, 0);
                chk("req_pulse_dir", up_pulse, up);
            end
            if (kk == n * SD + 1) chk("req_busy_end", busy, 0);
        end
        chk("req_pulse_count", pulses, n);
        chk("req_final_level", level, fin);
    endtask

    task automatic both_request();
        bit ok;
        @(posedge clk); #1;
        a_valid = 1; a_level = 3; b_valid = 1; b_level = 6;
        @(negedge clk);
        chk("tie_a_ready", a_ready, 1);
        chk("tie_b_ready", b_ready, 0);
        @(posedge clk); #1;
        a_valid = 0;
        wait_ready(1, ok);
        chk("tie_b_granted", ok, 1);
        chk("tie_level_at_b", level, 3);
        @(posedge clk); #1;
        b_valid = 0;
        repeat (3 * SD + 2) @(negedge clk);
        chk("tie_final_level", level, 6);
        chk("tie_owner_b", owner_b, 1);
    endtask

    initial begin
        bit ok;
        int cnt;
        bit acc_a, acc_b;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_up", up_pulse, 0);
        chk("rst_down", down_pulse, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner_b", owner_b, 0);
        reset = 0;

        request(0, 5, 5, 1, 5);
        request(1, 2, 3, 0, 2);
        chk("b_owner", owner_b, 1);
        request(0, 2, 0, 0, 2);
        chk("equal_owner", owner_b, 0);

        do_reset();
        both_request();

        do_reset();
        @(posedge clk); #1;
        a_valid = 1; a_level = 6;
        wait_ready(0, ok);
        chk("mid_granted", ok, 1);
        @(posedge clk); #1;
        a_valid = 0;
        wait_level(3, ok);
        chk("mid_reached3", ok, 1);
        chk("mid_busy_before", busy, 1);
        @(posedge clk); #2;
        reset = 1;
        #1;
        chk("mid_up", up_pulse, 0);
        chk("mid_down", down_pulse, 0);
        chk("mid_level", level, 0);
        chk("mid_busy", busy, 0);
        chk("mid_owner_b", owner_b, 0);
        chk("mid_a_ready", a_ready, 0);
        @(posedge clk); #1;
        reset = 0;
        both_request();

`ifdef LED_RAMP_ABORT_EN
        do_reset();
        @(posedge clk); #1;
        a_valid = 1; a_level = 6;
        wait_ready(0, ok);
        @(posedge clk); #1;
        a_valid = 0;
        wait_level(3, ok);
        chk("abort_reached3", ok, 1);
        @(posedge clk); #1;
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (up_pulse || down_pulse) cnt++;
        end
        chk("abort_pulses", cnt, 0);
        chk("abort_level", level, 3);
        chk("abort_busy", busy, 0);
`endif

        do_reset();
        @(posedge clk); #1;
        c_valid = 1; c_level = 7;
        wait_ready(2, ok);
        chk("clamp_granted", ok, 1);
        @(posedge clk); #1;
        c_valid = 0;
        cnt = 0;
        for (int i = 0; i < 5 * SD + 4; i++) begin
            @(negedge clk);
            if (c_up) cnt++;
            if (c_down) chk("clamp_no_down", c_down, 0);
        end
        chk("clamp_pulses", cnt, 5);
        chk("clamp_level", c_level_o, 5);
        chk("clamp_busy", c_busy, 0);

        do_reset();
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            @(posedge clk); #1;
            if (!a_valid || acc_a) begin
                a_valid = ($urandom_range(0, 2) == 0);
                a_level = 3'($urandom_range(0, 7));
            end
            if (!b_valid || acc_b) begin
                b_valid = ($urandom_range(0, 2) == 0);
                b_level = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 599) == 0) begin
                reset = 1;
                @(posedge clk); #1;
                reset = 0;
            end
        end
        a_valid = 0; b_valid = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
